// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALUOp encodings, $zero index, widths.
package id_ex_pipe_reg_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned RW_DEFAULT = 5;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_AND   = 2'b11
  } alu_op_e;

  localparam logic [RW_DEFAULT-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_pipe_reg_hazard_detect.sv
// Combinational ID-stage stall detection: load-use and branch-operand hazards against the
// instructions currently in EX and MEM.
module id_ex_pipe_reg_hazard_detect
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned RW = RW_DEFAULT
) (
  input  logic          uses_rs,
  input  logic          uses_rt,
  input  logic          id_branch,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] ex_dest,
  input  logic          ex_mem_read,
  input  logic          ex_reg_write,
  input  logic [RW-1:0] mem_dest,
  input  logic          mem_mem_read,
  output logic          stall
);

  // A write to $zero is never a real dependency.
  function automatic logic hit(input logic [RW-1:0] d, input logic u_rs, input logic u_rt,
                               input logic [RW-1:0] rs, input logic [RW-1:0] rt);
    return (d != RW'(REG_ZERO)) && ((u_rs && d == rs) || (u_rt && d == rt));
  endfunction

  logic ex_hit;
  logic mem_hit;

  always_comb begin
    ex_hit  = hit(ex_dest, uses_rs, uses_rt, id_rs, id_rt);
    mem_hit = hit(mem_dest, uses_rs, uses_rt, id_rs, id_rt);
    stall   = (ex_mem_read && ex_hit)
            | (id_branch && ex_reg_write && ex_hit)
            | (id_branch && mem_mem_read && mem_hit);
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hazard stall/flush generation.
// Define IDEX_PERF_CNT_EN to add stall_cnt/flush_cnt event counters.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned RW = RW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_reg_dst,
  input  logic          id_mem_read,
  input  logic          id_mem_to_reg,
  input  logic          id_mem_write,
  input  logic          id_alu_src,
  input  logic          id_reg_write,
  input  logic [1:0]    id_alu_op,
  input  logic          id_branch,
  input  logic          id_branch_take,
  input  logic          id_jump,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  output logic          ex_reg_dst,
  output logic          ex_mem_read,
  output logic          ex_mem_to_reg,
  output logic          ex_mem_write,
  output logic          ex_alu_src,
  output logic          ex_reg_write,
  output logic [1:0]    ex_alu_op,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [RW-1:0] ex_rs,
  output logic [RW-1:0] ex_rt,
  output logic [RW-1:0] ex_rd,
  output logic [RW-1:0] ex_dest,
  output logic          pc_write,
  output logic          ifid_write,
  output logic          if_flush
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  logic          uses_rs;
  logic          uses_rt;
  logic          stall;
  logic [RW-1:0] mem_dest_q;
  logic          mem_reg_write_q;
  logic          mem_mem_read_q;

  always_comb begin
    uses_rs    = ~id_jump;
    uses_rt    = ~id_alu_src | id_mem_write;
    pc_write   = ~stall;
    ifid_write = ~stall;
    // A stalled branch sees stale operands, so its outcome cannot be trusted yet.
    if_flush   = ~stall & (id_jump | (id_branch & id_branch_take));
  end

  id_ex_pipe_reg_hazard_detect #(
    .RW (RW)
  ) u_hazard_detect (
    .uses_rs      (uses_rs),
    .uses_rt      (uses_rt),
    .id_branch    (id_branch),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_dest      (ex_dest),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .mem_dest     (mem_dest_q),
    .mem_mem_read (mem_mem_read_q),
    .stall        (stall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_reg_dst      <= 1'b0;
      ex_mem_read     <= 1'b0;
      ex_mem_to_reg   <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_alu_src      <= 1'b0;
      ex_reg_write    <= 1'b0;
      ex_alu_op       <= ALUOP_ADD;
      ex_rs_data      <= '0;
      ex_rt_data      <= '0;
      ex_imm          <= '0;
      ex_rs           <= '0;
      ex_rt           <= '0;
      ex_rd           <= '0;
      ex_dest         <= '0;
      mem_dest_q      <= '0;
      mem_reg_write_q <= 1'b0;
      mem_mem_read_q  <= 1'b0;
    end else begin
      mem_dest_q      <= ex_dest;
      mem_reg_write_q <= ex_reg_write;
      mem_mem_read_q  <= ex_mem_read;
      // Data fields follow ID even during a bubble; only the controls must be cleared.
      ex_rs_data      <= id_rs_data;
      ex_rt_data      <= id_rt_data;
      ex_imm          <= id_imm;
      ex_rs           <= id_rs;
      ex_rt           <= id_rt;
      ex_rd           <= id_rd;
      ex_dest         <= id_reg_dst ? id_rd : id_rt;
      if (stall) begin
        ex_reg_dst    <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_to_reg <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_alu_src    <= 1'b0;
        ex_reg_write  <= 1'b0;
        ex_alu_op     <= ALUOP_ADD;
      end else begin
        ex_reg_dst    <= id_reg_dst;
        ex_mem_read   <= id_mem_read;
        ex_mem_to_reg <= id_mem_to_reg;
        ex_mem_write  <= id_mem_write;
        ex_alu_src    <= id_alu_src;
        ex_reg_write  <= id_reg_write;
        ex_alu_op     <= id_alu_op;
      end
    end
  end

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (if_flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed hazard scenarios then random traffic,
// checked against a slot-history pipeline model. Counter checks only with IDEX_PERF_CNT_EN.
module tb_id_ex_pipe_reg;
  import id_ex_pipe_reg_pkg::*;

  typedef struct {
    logic        reg_dst, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic        branch, take, jump;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
  } instr_t;

  typedef struct {
    logic [4:0] dest;
    bit         reg_write;
    bit         mem_read;
  } slot_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  instr_t      cur;
  logic        ex_reg_dst, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0]  ex_alu_op;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_dest;
  logic        pc_write, ifid_write, if_flush;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  id_ex_pipe_reg dut (
    .clk            (clk),
    .reset          (reset),
    .id_reg_dst     (cur.reg_dst),
    .id_mem_read    (cur.mem_read),
    .id_mem_to_reg  (cur.mem_to_reg),
    .id_mem_write   (cur.mem_write),
    .id_alu_src     (cur.alu_src),
    .id_reg_write   (cur.reg_write),
    .id_alu_op      (cur.alu_op),
    .id_branch      (cur.branch),
    .id_branch_take (cur.take),
    .id_jump        (cur.jump),
    .id_rs_data     (cur.rs_data),
    .id_rt_data     (cur.rt_data),
    .id_imm         (cur.imm),
    .id_rs          (cur.rs),
    .id_rt          (cur.rt),
    .id_rd          (cur.rd),
    .ex_reg_dst     (ex_reg_dst),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_mem_write   (ex_mem_write),
    .ex_alu_src     (ex_alu_src),
    .ex_reg_write   (ex_reg_write),
    .ex_alu_op      (ex_alu_op),
    .ex_rs_data     (ex_rs_data),
    .ex_rt_data     (ex_rt_data),
    .ex_imm         (ex_imm),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_rd          (ex_rd),
    .ex_dest        (ex_dest),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .if_flush       (if_flush)
`ifdef IDEX_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  slot_t       ex_s, mem_s;
  instr_t      exp_ex;
  logic [4:0]  exp_dest;
  bit          data_chk;
  logic [31:0] m_stall_cnt, m_flush_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t nop();
    instr_t r;
    r = '{default: '0};
    return r;
  endfunction

  function automatic instr_t mk_lw(input logic [4:0] rt, input logic [4:0] rs);
    instr_t r = nop();
    r.mem_read = 1; r.mem_to_reg = 1; r.alu_src = 1; r.reg_write = 1; r.alu_op = ALUOP_ADD;
    r.rs = rs; r.rt = rt; r.rs_data = $urandom; r.imm = $urandom;
    return r;
  endfunction

  function automatic instr_t mk_add(input logic [4:0] rd, input logic [4:0] rs,
                                    input logic [4:0] rt);
    instr_t r = nop();
    r.reg_dst = 1; r.reg_write = 1; r.alu_op = ALUOP_RTYPE;
    r.rs = rs; r.rt = rt; r.rd = rd; r.rs_data = $urandom; r.rt_data = $urandom;
    return r;
  endfunction

  function automatic instr_t mk_addi(input logic [4:0] rt, input logic [4:0] rs,
                                     input logic [31:0] imm);
    instr_t r = nop();
    r.alu_src = 1; r.reg_write = 1; r.alu_op = ALUOP_ADD;
    r.rs = rs; r.rt = rt; r.imm = imm; r.rs_data = $urandom;
    return r;
  endfunction

  function automatic instr_t mk_br(input logic [4:0] rs, input logic [4:0] rt, input bit take);
    instr_t r = nop();
    r.branch = 1; r.take = take; r.alu_op = ALUOP_SUB;
    r.rs = rs; r.rt = rt; r.rs_data = $urandom; r.rt_data = $urandom; r.imm = $urandom;
    return r;
  endfunction

  function automatic instr_t mk_j(input logic [4:0] rs);
    instr_t r = nop();
    r.jump = 1; r.rs = rs; r.imm = $urandom;
    return r;
  endfunction

  function automatic instr_t mk_rand();
    instr_t r;
    r.reg_dst = 1'($urandom_range(0, 1));  r.mem_read = 1'($urandom_range(0, 1));
    r.mem_to_reg = 1'($urandom_range(0, 1)); r.mem_write = 1'($urandom_range(0, 1));
    r.alu_src = 1'($urandom_range(0, 1));  r.reg_write = 1'($urandom_range(0, 1));
    r.alu_op = 2'($urandom_range(0, 3));   r.branch = 1'($urandom_range(0, 1));
    r.take = 1'($urandom_range(0, 1));     r.jump = 1'($urandom_range(0, 1));
    r.rs_data = $urandom; r.rt_data = $urandom; r.imm = $urandom;
    r.rs = 5'($urandom_range(0, 3)); r.rt = 5'($urandom_range(0, 3));
    r.rd = 5'($urandom_range(0, 3));
    return r;
  endfunction

  // Does the instruction read a register that slot s is about to write?
  function automatic bit m_hit(input slot_t s, input instr_t i);
    bit reads_rs = !i.jump;
    bit reads_rt = !i.alu_src || i.mem_write;
    return (s.dest != 0) && ((reads_rs && s.dest == i.rs) || (reads_rt && s.dest == i.rt));
  endfunction

  function automatic bit m_stall(input instr_t i);
    if (ex_s.mem_read && m_hit(ex_s, i)) return 1;
    if (i.branch && ex_s.reg_write && m_hit(ex_s, i)) return 1;
    if (i.branch && mem_s.mem_read && m_hit(mem_s, i)) return 1;
    return 0;
  endfunction

  // One cycle: drive at posedge+1, check hazard outputs at negedge, check EX at next posedge+1.
  task automatic step(input instr_t i, input bit rst, output bit st);
    bit fl;
    cur   = i;
    reset = rst;
    #4;
    st = m_stall(i);
    fl = !st && (i.jump || (i.branch && i.take));
    check("pc_write", pc_write, !st);
    check("ifid_write", ifid_write, !st);
    check("if_flush", if_flush, fl);
    @(posedge clk);
    if (rst) begin
      exp_ex      = nop();
      exp_dest    = '0;
      data_chk    = 1;
      ex_s        = '{dest: '0, reg_write: 0, mem_read: 0};
      mem_s       = ex_s;
      m_stall_cnt = '0;
      m_flush_cnt = '0;
    end else begin
      if (st) m_stall_cnt = m_stall_cnt + 1;
      if (fl) m_flush_cnt = m_flush_cnt + 1;
      mem_s    = ex_s;
      exp_ex   = i;
      exp_dest = i.reg_dst ? i.rd : i.rt;
      data_chk = !st;
      if (st) begin
        exp_ex.reg_dst = 0; exp_ex.mem_read = 0; exp_ex.mem_to_reg = 0;
        exp_ex.mem_write = 0; exp_ex.alu_src = 0; exp_ex.reg_write = 0; exp_ex.alu_op = 0;
      end
      ex_s = '{dest: exp_dest, reg_write: exp_ex.reg_write, mem_read: exp_ex.mem_read};
    end
    #1;
    check("ex_reg_dst", ex_reg_dst, exp_ex.reg_dst);
    check("ex_mem_read", ex_mem_read, exp_ex.mem_read);
    check("ex_mem_to_reg", ex_mem_to_reg, exp_ex.mem_to_reg);
    check("ex_mem_write", ex_mem_write, exp_ex.mem_write);
    check("ex_alu_src", ex_alu_src, exp_ex.alu_src);
    check("ex_reg_write", ex_reg_write, exp_ex.reg_write);
    check("ex_alu_op", ex_alu_op, exp_ex.alu_op);
    if (data_chk) begin
      check("ex_rs_data", ex_rs_data, exp_ex.rs_data);
      check("ex_rt_data", ex_rt_data, exp_ex.rt_data);
      check("ex_imm", ex_imm, exp_ex.imm);
      check("ex_rs", ex_rs, exp_ex.rs);
      check("ex_rt", ex_rt, exp_ex.rt);
      check("ex_rd", ex_rd, exp_ex.rd);
      check("ex_dest", ex_dest, exp_dest);
    end
`ifdef IDEX_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_stall_cnt);
    check("flush_cnt", flush_cnt, m_flush_cnt);
`endif
  endtask

  // Present an instruction until it leaves ID, counting stall cycles (bounded).
  task automatic issue(input string tag, input instr_t i, input int exp_n);
    bit st;
    int n = 0;
    do begin
      step(i, 0, st);
      if (st) n++;
    end while (st && n < 5);
    check({"stalls_", tag}, n, exp_n);
  endtask

  initial begin
    bit st;
    cur         = nop();
    reset       = 1;
    ex_s        = '{dest: '0, reg_write: 0, mem_read: 0};
    mem_s       = ex_s;
    m_stall_cnt = '0;
    m_flush_cnt = '0;
    @(posedge clk);
    #1;
    step(nop(), 1, st);
    step(nop(), 1, st);

    // Load-use: one bubble, then the add enters EX.
    issue("t1_lw", mk_lw(5'd2, 5'd1), 0);
    issue("t1_add", mk_add(5'd3, 5'd2, 5'd4), 1);

    // ALU -> branch stalls once; load -> branch stalls twice, then the taken branch flushes.
    issue("t2_nop", nop(), 0);
    issue("t2_add", mk_add(5'd2, 5'd1, 5'd1), 0);
    issue("t2_bne_nt", mk_br(5'd2, 5'd5, 0), 1);
    issue("t2_lw", mk_lw(5'd2, 5'd1), 0);
    issue("t2_beq_t", mk_br(5'd2, 5'd5, 1), 2);
`ifdef IDEX_PERF_CNT_EN
    check("t6_stall_cnt", stall_cnt, 32'd4);
    check("t6_flush_cnt", flush_cnt, 32'd1);
`endif

    // $zero destination and forwardable ALU results never stall.
    issue("t3_nop", nop(), 0);
    issue("t3_lw0", mk_lw(5'd0, 5'd1), 0);
    issue("t3_add0", mk_add(5'd3, 5'd0, 5'd4), 0);
    issue("t3_addi", mk_addi(5'd2, 5'd1, 32'd5), 0);
    issue("t3_add", mk_add(5'd3, 5'd2, 5'd2), 0);

    // Jump uses no operand after a load; not-taken branch does not flush.
    issue("t4_lw", mk_lw(5'd2, 5'd1), 0);
    issue("t4_j", mk_j(5'd2), 0);
    issue("t4_bne", mk_br(5'd6, 5'd7, 0), 0);

    // Reset on the second stall cycle of load/branch clears the whole stall chain.
    issue("t5_nop", nop(), 0);
    issue("t5_lw", mk_lw(5'd2, 5'd1), 0);
    step(mk_br(5'd2, 5'd5, 1), 0, st);
    step(mk_br(5'd2, 5'd5, 1), 1, st);
    check("t5_post_reset_pc_write", pc_write, 1);
    check("t5_post_reset_if_flush", if_flush, 1);
    step(mk_br(5'd2, 5'd5, 1), 0, st);

    for (int k = 0; k < 400; k++) begin
      step(mk_rand(), ($urandom_range(0, 49) == 0), st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
